tcam_search_engine: RTL and testbench
=====================================

// Module: tcam_search_engine
// PURPOSE
// Parametrised, pipelined successor of the 4x7x64 TCAM macro wrapper. Key is split into NUM_BLOCKS slices of SLICE_W bits.
// Each slice indexes a per-block row table of ENTRIES-bit match vectors. Rows are ANDed and priority-encoded.
// Adds a valid/ready command port, a registered 2-stage search pipeline with response backpressure, and a hit flag.
// Sits between the RoCC command decoder and the TCAM storage, replacing the bare combinational search path.
// PARAMETERS
// NUM_BLOCKS  4   key slices / row tables; power of 2, >=2
// SLICE_W     7   bits per key slice; each table has 2**SLICE_W rows
// ENTRIES     64  TCAM entries (match vector width); multiple of 8, >=8
// KEY_W = NUM_BLOCKS*SLICE_W (localparam, 28); PMA_W = $clog2(ENTRIES) (6); BSEL_W = $clog2(NUM_BLOCKS) (2)
// PORTS
// in_clk         in   1             clock
// in_rst         in   1             synchronous reset, active-high
// in_cmd_valid   in   1             command valid
// out_cmd_ready  out  1             command accepted when valid&&ready
// in_cmd_we      in   1             1=write row, 0=search
// in_cmd_addr    in   KEY_W         search: key; write: row=[SLICE_W-1:0], block=[SLICE_W+:BSEL_W], rest ignored
// in_cmd_wdata   in   ENTRIES       row write data
// in_cmd_wmask   in   ENTRIES/8     byte write enables (bit i -> wdata[8i+:8])
// out_rsp_valid  out  1             search result valid
// in_rsp_ready   in   1             result consumed when valid&&ready
// out_rsp_hit    out  1             at least one entry matched
// out_rsp_pma    out  PMA_W         lowest matching entry index; 0 on miss
// out_rsp_count  out  $clog2(ENTRIES+1)  number of matching entries (only with TCAM_MULTIHIT_EN)
// BEHAVIOUR
// - Reset: all row tables cleared to 0, out_rsp_valid=0, out_rsp_hit=0, out_rsp_pma=0, out_rsp_count=0, stage-1 valid=0.
//   Reset dominates any concurrent command; pending searches are dropped.
// - stall = out_rsp_valid && !in_rsp_ready. out_cmd_ready = !(stall && s1_valid). Same rule for writes and searches.
// - Write (accepted, we=1): at that edge, table[block][row] bytes with wmask=1 take wdata; others hold. No response.
// - Search (accepted, we=0): at that edge, stage 1 registers table[b][key[b*SLICE_W+:SLICE_W]] for every b.
//   It reads pre-edge contents, so a write accepted in the same cycle is impossible (one command per cycle).
//   A write accepted in the cycle after a search does not affect that search.
//   A search accepted after a write sees the written data.
// - Stage 2: AND of all NUM_BLOCKS rows. The result register loads when s1_valid && !stall.
//   hit=|vec; pma = lowest set index, else 0.
// - Latency: response valid 2 cycles after acceptance with no stall. Throughput: 1 search/cycle.
// - Backpressure: while stalled, output regs and stage 1 hold. Up to 2 searches are in flight.
//   Responses are strictly in order, with none lost or duplicated.
// - out_rsp_valid clears on handshake when stage 1 is empty. Valid/ready handshake on both ports.
//   Outputs are stable while valid && !ready.
// - ENTRIES=8: wmask is 1 bit. All-ones vector: pma=0, count=ENTRIES.
// CONFIGURATION
// - `TCAM_MULTIHIT_EN defined: out_rsp_count port present, = popcount of AND vector, registered with pma.
// - Not defined: port absent; no popcount logic. Other behaviour is identical.
// TESTING
// 1. Reset, then search key 28'h0 -> rsp_valid 2 cycles after accept, hit=0, pma=0 (count=0).
// 2. Write block b row b+1 (b=0..3) wdata=64'h20, wmask=8'hFF; search key {7'd4,7'd3,7'd2,7'd1} -> hit=1, pma=5.
// 3. Additionally OR bit 2 into the same 4 rows; same search -> pma=2; with TCAM_MULTIHIT_EN count=2.
// 4. Row block0/row0 = 0; write wdata=all-ones, wmask=8'h01; search with other blocks' rows all-ones -> hit, pma=0.
//    The result vector is 64'hFF (count=8).
// 5. Hold rsp_ready=0, issue 3 back-to-back searches -> 2 accepted, then ready=0. Release ready -> 3 in-order responses.
//    No bubbles are inserted after release.
// 6. Assert in_rst one cycle with 2 searches in flight -> next cycle rsp_valid=0, no stale response.
//    The rows of case 2 are cleared, so a repeat search misses.

Source files
------------

// File: rtl/tcam_search_engine.sv
`default_nettype none
// ============================================================================
// Module   : tcam_search_engine
// Brief    : Pipelined sliced-key TCAM search with byte-masked row writes,
//            valid/ready command/response ports and a hit flag.
//            Optional match count output enabled by `TCAM_MULTIHIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tcam_search_engine #(
    parameter int NUM_BLOCKS = 4,
    parameter int SLICE_W    = 7,
    parameter int ENTRIES    = 64
) (
    input  logic                                 in_clk,
    input  logic                                 in_rst,
    input  logic                                 in_cmd_valid,
    output logic                                 out_cmd_ready,
    input  logic                                 in_cmd_we,
    input  logic [NUM_BLOCKS*SLICE_W-1:0]        in_cmd_addr,
    input  logic [ENTRIES-1:0]                   in_cmd_wdata,
    input  logic [ENTRIES/8-1:0]                 in_cmd_wmask,
    output logic                                 out_rsp_valid,
    input  logic                                 in_rsp_ready,
    output logic                                 out_rsp_hit,
`ifdef TCAM_MULTIHIT_EN
    output logic [$clog2(ENTRIES+1)-1:0]         out_rsp_count,
`endif
    output logic [$clog2(ENTRIES)-1:0]           out_rsp_pma
);

    localparam int KEY_W  = NUM_BLOCKS * SLICE_W;
    localparam int PMA_W  = $clog2(ENTRIES);
    localparam int BSEL_W = $clog2(NUM_BLOCKS);
    localparam int ROWS   = 2 ** SLICE_W;
    localparam int BYTES  = ENTRIES / 8;
`ifdef TCAM_MULTIHIT_EN
    localparam int CNT_W  = $clog2(ENTRIES + 1);
`endif

    logic [ENTRIES-1:0] r_table   [NUM_BLOCKS][ROWS];
    logic [ENTRIES-1:0] r_s1_rows [NUM_BLOCKS];
    logic               r_s1_valid;
    logic               r_rsp_valid;
    logic               r_rsp_hit;
    logic [PMA_W-1:0]   r_rsp_pma;

    logic               w_stall;
    logic               w_cmd_ready;
    logic               w_wr_acc;
    logic               w_srch_acc;
    logic               w_s1_adv;
    logic [BSEL_W-1:0]  w_wr_blk;
    logic [SLICE_W-1:0] w_wr_row;
    logic [SLICE_W-1:0] w_slice [NUM_BLOCKS];
    logic [ENTRIES-1:0] w_vec;
    logic               w_hit;
    logic [PMA_W-1:0]   w_pma;

    assign w_stall     = r_rsp_valid && !in_rsp_ready;
    assign w_cmd_ready = !(w_stall && r_s1_valid);
    assign w_wr_acc    = in_cmd_valid && w_cmd_ready && in_cmd_we;
    assign w_srch_acc  = in_cmd_valid && w_cmd_ready && !in_cmd_we;
    // Stage 1 may refill whenever it is empty, even while the output is stalled.
    assign w_s1_adv    = !w_stall || !r_s1_valid;
    assign w_wr_row    = in_cmd_addr[SLICE_W-1:0];
    assign w_wr_blk    = in_cmd_addr[SLICE_W +: BSEL_W];

    generate
        for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_slice
            assign w_slice[b] = in_cmd_addr[b*SLICE_W +: SLICE_W];
        end
    endgenerate

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_table[b][r] <= '0;
                end
            end
        end else if (w_wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (in_cmd_wmask[i]) begin
                    r_table[w_wr_blk][w_wr_row][8*i +: 8] <= in_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_s1_valid <= 1'b0;
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                r_s1_rows[b] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= w_srch_acc;
            if (w_srch_acc) begin
                for (int b = 0; b < NUM_BLOCKS; b++) begin
                    r_s1_rows[b] <= r_table[b][w_slice[b]];
                end
            end
        end
    end

    always_comb begin
        w_vec = '1;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            w_vec = w_vec & r_s1_rows[b];
        end
    end

    // Scan from the top so the lowest set index wins.
    always_comb begin
        w_hit = |w_vec;
        w_pma = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_vec[i]) begin
                w_pma = PMA_W'(i);
            end
        end
    end

`ifdef TCAM_MULTIHIT_EN
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_rsp_count;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_cnt = w_cnt + CNT_W'(w_vec[i]);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rsp_count <= '0;
        end else if (!w_stall && r_s1_valid) begin
            r_rsp_count <= w_cnt;
        end
    end

    assign out_rsp_count = r_rsp_count;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_pma   <= '0;
        end else if (!w_stall) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_hit <= w_hit;
                r_rsp_pma <= w_pma;
            end
        end
    end

    assign out_cmd_ready = w_cmd_ready;
    assign out_rsp_valid = r_rsp_valid;
    assign out_rsp_hit   = r_rsp_hit;
    assign out_rsp_pma   = r_rsp_pma;

endmodule
`default_nettype wire

// File: tb/tb_tcam_search_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcam_search_engine
// Brief    : Self-checking bench: vector table, corner sequences, random
//            traffic against a scoreboard reference of the row tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcam_search_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [27:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [5:0]  rsp_pma;
`ifdef TCAM_MULTIHIT_EN
    logic [6:0]  rsp_count;
`endif

    tcam_search_engine dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_cmd_valid  (cmd_valid),
        .out_cmd_ready (cmd_ready),
        .in_cmd_we     (cmd_we),
        .in_cmd_addr   (cmd_addr),
        .in_cmd_wdata  (cmd_wdata),
        .in_cmd_wmask  (cmd_wmask),
        .out_rsp_valid (rsp_valid),
        .in_rsp_ready  (rsp_ready),
        .out_rsp_hit   (rsp_hit),
`ifdef TCAM_MULTIHIT_EN
        .out_rsp_count (rsp_count),
`endif
        .out_rsp_pma   (rsp_pma)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        logic [5:0]  pma;
        logic [6:0]  cnt;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [27:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        bit          hit;
        logic [5:0]  pma;
        logic [6:0]  cnt;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] mt [4][128];
    rsp_t        exp_q [$];
    bit          acc;
    bit          got;
    rsp_t        last;
    bit          prev_stall = 1'b0;
    bit          ph;
    logic [5:0]  pp;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: AND the addressed rows, find the first set bit by a forward scan.
    function automatic rsp_t ref_search(input logic [27:0] key);
        rsp_t        r;
        logic [63:0] v;
        int          i;
        v = '1;
        for (int b = 0; b < 4; b++) v = v & mt[b][key[b*7 +: 7]];
        i = 0;
        while (i < 64 && !v[i]) i++;
        r.hit = (v != 0);
        r.pma = (i < 64) ? i[5:0] : 6'd0;
        r.cnt = 7'($countones(v));
        return r;
    endfunction

    task automatic observe();
        rsp_t e;
        if (rst) begin
            exp_q.delete();
            for (int b = 0; b < 4; b++)
                for (int r = 0; r < 128; r++) mt[b][r] = '0;
            prev_stall = 1'b0;
            acc = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk(rsp_valid && rsp_hit == ph && rsp_pma == pp, "stall_hold",
                {57'd0, rsp_valid, rsp_pma}, {57'd1, pp});
        end
        if (rsp_valid && rsp_ready) begin
            chk(exp_q.size() != 0, "rsp_unexpected", 64'd1, 64'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(rsp_hit == e.hit, "sb_hit", 64'(rsp_hit), 64'(e.hit));
                chk(rsp_pma == e.pma, "sb_pma", 64'(rsp_pma), 64'(e.pma));
`ifdef TCAM_MULTIHIT_EN
                chk(rsp_count == e.cnt, "sb_count", 64'(rsp_count), 64'(e.cnt));
                last.cnt = rsp_count;
`endif
            end
            got      = 1'b1;
            last.hit = rsp_hit;
            last.pma = rsp_pma;
        end
        prev_stall = rsp_valid && !rsp_ready;
        ph = rsp_hit;
        pp = rsp_pma;
        acc = cmd_valid && cmd_ready;
        if (acc) begin
            if (cmd_we) begin
                for (int i = 0; i < 8; i++)
                    if (cmd_wmask[i])
                        mt[cmd_addr[8:7]][cmd_addr[6:0]][8*i +: 8] = cmd_wdata[8*i +: 8];
            end else begin
                exp_q.push_back(ref_search(cmd_addr));
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit we, input logic [27:0] a,
                        input logic [63:0] wd, input logic [7:0] wm, input bit rr);
        @(negedge clk);
        rst       = r;
        cmd_valid = v;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = wm;
        rsp_ready = rr;
        #1;
        observe();
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 1'b0, 1'b0, 28'd0, 64'd0, 8'd0, rr);
    endtask

    task automatic apply(input vec_t t, input string nm);
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            step(1'b0, 1'b1, t.we, t.addr, t.wdata, t.wmask, 1'b1);
            n++;
        end
        chk(acc, {nm, "_accept"}, 64'(acc), 64'd1);
        if (!t.we) begin
            got = 1'b0;
            n = 0;
            while (!got && n < 50) begin
                idle(1'b1);
                n++;
            end
            chk(got, {nm, "_rsp"}, 64'(got), 64'd1);
            chk(last.hit == t.hit, {nm, "_hit"}, 64'(last.hit), 64'(t.hit));
            chk(last.pma == t.pma, {nm, "_pma"}, 64'(last.pma), 64'(t.pma));
`ifdef TCAM_MULTIHIT_EN
            chk(last.cnt == t.cnt, {nm, "_count"}, 64'(last.cnt), 64'(t.cnt));
`endif
        end
    endtask

    function automatic vec_t wr(input int b, input int r, input logic [63:0] d, input logic [7:0] m);
        vec_t t;
        t.we = 1'b1; t.addr = 28'((b << 7) | r); t.wdata = d; t.wmask = m;
        t.hit = 1'b0; t.pma = '0; t.cnt = '0;
        return t;
    endfunction

    function automatic vec_t sr(input logic [27:0] k, input bit h, input logic [5:0] p, input logic [6:0] c);
        vec_t t;
        t.we = 1'b0; t.addr = k; t.wdata = '0; t.wmask = '0;
        t.hit = h; t.pma = p; t.cnt = c;
        return t;
    endfunction

    initial begin
        vec_t        tbl [$];
        logic [27:0] k2;
        logic [27:0] kmiss;
        int          n_acc;
        bit          pend;
        bit          we_p;
        logic [27:0] addr_p;
        logic [63:0] wd_p;
        logic [7:0]  wm_p;
        int          n;

        k2    = {7'd4, 7'd3, 7'd2, 7'd1};
        kmiss = {7'd9, 7'd9, 7'd9, 7'd9};
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;

        step(1'b1, 1'b0, 1'b0, 28'd0, 64'd0, 8'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 28'd0, 64'd0, 8'd0, 1'b1);
        idle(1'b1);
        chk(rsp_valid == 1'b0, "rst_valid", 64'(rsp_valid), 64'd0);
        chk(rsp_hit == 1'b0, "rst_hit", 64'(rsp_hit), 64'd0);
        chk(rsp_pma == 6'd0, "rst_pma", 64'(rsp_pma), 64'd0);
        chk(cmd_ready == 1'b1, "rst_ready", 64'(cmd_ready), 64'd1);

        // Empty tables miss; response appears exactly two cycles after acceptance.
        step(1'b0, 1'b1, 1'b0, 28'd0, 64'd0, 8'd0, 1'b1);
        chk(acc, "lat_accept", 64'(acc), 64'd1);
        idle(1'b1);
        chk(rsp_valid == 1'b0, "lat_cycle1", 64'(rsp_valid), 64'd0);
        got = 1'b0;
        idle(1'b1);
        chk(rsp_valid == 1'b1 && got, "lat_cycle2", 64'(rsp_valid), 64'd1);
        chk(rsp_hit == 1'b0 && rsp_pma == 6'd0, "miss_result", {57'd0, rsp_hit, rsp_pma}, 64'd0);

        for (int b = 0; b < 4; b++) tbl.push_back(wr(b, b + 1, 64'h20, 8'hFF));
        tbl.push_back(sr(k2, 1'b1, 6'd5, 7'd1));
        for (int b = 0; b < 4; b++) tbl.push_back(wr(b, b + 1, 64'h24, 8'hFF));
        tbl.push_back(sr(k2, 1'b1, 6'd2, 7'd2));
        for (int b = 1; b < 4; b++) tbl.push_back(wr(b, 0, '1, 8'hFF));
        tbl.push_back(wr(0, 0, '1, 8'h01));
        tbl.push_back(sr(28'd0, 1'b1, 6'd0, 7'd8));
        tbl.push_back(sr(kmiss, 1'b0, 6'd0, 7'd0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: two searches fit in the pipe, the third waits.
        n_acc = 0;
        step(1'b0, 1'b1, 1'b0, k2, 64'd0, 8'd0, 1'b0);    if (acc) n_acc++;
        step(1'b0, 1'b1, 1'b0, 28'd0, 64'd0, 8'd0, 1'b0); if (acc) n_acc++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, kmiss, 64'd0, 8'd0, 1'b0);
            if (acc) n_acc++;
        end
        chk(n_acc == 2, "bp_accepted", 64'(n_acc), 64'd2);
        chk(cmd_ready == 1'b0, "bp_ready_low", 64'(cmd_ready), 64'd0);
        got = 1'b0;
        step(1'b0, 1'b1, 1'b0, kmiss, 64'd0, 8'd0, 1'b1);
        chk(got && acc, "bp_rel0", {62'd0, got, acc}, 64'd3);
        got = 1'b0;
        idle(1'b1);
        chk(got, "bp_rel1", 64'(got), 64'd1);
        got = 1'b0;
        idle(1'b1);
        chk(got, "bp_rel2", 64'(got), 64'd1);
        idle(1'b1);
        chk(rsp_valid == 1'b0, "bp_drained", 64'(rsp_valid), 64'd0);

        // Reset with two searches in flight drops them and clears the tables.
        step(1'b0, 1'b1, 1'b0, k2, 64'd0, 8'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, k2, 64'd0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 28'd0, 64'd0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk(rsp_valid == 1'b0, "rst_flush", 64'(rsp_valid), 64'd0);
        end
        apply(sr(k2, 1'b0, 6'd0, 7'd0), "rst_cleared");

        // Random traffic; commands are held until accepted.
        pend = 1'b0; we_p = 1'b0; addr_p = '0; wd_p = '0; wm_p = '0;
        for (int it = 0; it < 2000; it++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                we_p = ($urandom_range(0, 2) == 0);
                addr_p = 28'($urandom);
                if (we_p) begin
                    addr_p[8:0] = {2'($urandom_range(0, 3)), 7'($urandom_range(0, 3))};
                    wd_p = {$urandom, $urandom} | {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) wd_p = {$urandom, $urandom};
                    wm_p = 8'($urandom);
                end else begin
                    for (int b = 0; b < 4; b++) addr_p[b*7 +: 7] = 7'($urandom_range(0, 3));
                end
            end
            step(1'b0, pend, we_p, addr_p, wd_p, wm_p, ($urandom_range(0, 3) != 0));
            if (acc) pend = 1'b0;
        end
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            idle(1'b1);
            n++;
        end
        chk(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
